// File: rtl/riscv32_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds funct3 encodings, the 2-bit FSM state encoding and the request legality check.
package riscv32_lsu_pkg;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RD_ISSUE = 2'b01,
    ST_RD_DATA  = 2'b10,
    ST_WR_ISSUE = 2'b11
  } lsu_state_t;

  // Any request that must be answered with resp_err instead of touching the RAM.
  function automatic logic lsu_req_err(input logic       wr,
                                       input logic [2:0] f3,
                                       input logic [1:0] off,
                                       input logic       out_of_range);
    logic bad;
    bad = out_of_range || (wr && f3[2]);
    case (f3)
      LSU_F3_H, LSU_F3_HU:    bad = bad || off[0];
      LSU_F3_W:               bad = bad || (off != 2'b00);
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv32_lsu_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; lanes are little-endian within the 32-bit word.
module riscv32_lsu_align
  import riscv32_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];

    load_data = word;
    case (funct3)
      LSU_F3_B:  load_data = {{24{lane_b[7]}}, lane_b};
      LSU_F3_H:  load_data = {{16{lane_h[15]}}, lane_h};
      LSU_F3_BU: load_data = {24'd0, lane_b};
      LSU_F3_HU: load_data = {16'd0, lane_h};
      default:   load_data = word;
    endcase

    merged = word;
    case (funct3)
      LSU_F3_B: merged[{off, 3'b000} +: 8]     = wdata[7:0];
      LSU_F3_H: merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default:  merged = word;
    endcase
  end

endmodule

// File: rtl/riscv32_lsu.sv
// RV32I load/store unit driving a word-wide single-port RAM with 1-cycle read latency.
// Sub-word stores are done as read-modify-write since the RAM has no byte enables.
//
// state       | meaning
// ST_IDLE     | waiting for a request; req_ready high
// ST_RD_ISSUE | RAM read enabled for the latched word address
// ST_RD_DATA  | mem_rdata valid; load result or merged store word captured
// ST_WR_ISSUE | RAM write of mem_wdata
module riscv32_lsu
  import riscv32_lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_next;
  logic        accept;
  logic        req_bad;
  logic        out_of_range;
  logic        wr_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready    = reset_n && (state == ST_IDLE);
  assign accept       = req_valid && req_ready;
  assign out_of_range = (req_addr >> MEM_ADDR_BITS) != 32'd0;
  assign req_bad      = lsu_req_err(req_wr, req_funct3, req_addr[1:0], out_of_range);

  riscv32_lsu_align u_align (
    .word      (mem_rdata),
    .off       (off_q),
    .funct3    (funct3_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_wen    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !req_bad)
          state_next = (req_wr && req_funct3 == LSU_F3_W) ? ST_WR_ISSUE : ST_RD_ISSUE;
      end
      ST_RD_ISSUE: begin
        mem_en     = 1'b1;
        state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        state_next = wr_q ? ST_WR_ISSUE : ST_IDLE;
      end
      ST_WR_ISSUE: begin
        mem_en     = 1'b1;
        mem_wen    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers; response fields default to zero so resp_valid is a single pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_q     <= req_wr;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_wr && req_funct3 == LSU_F3_W) mem_wdata <= req_wdata;
            end
          end
        end
        ST_RD_DATA: begin
          if (wr_q) begin
            mem_wdata <= merged;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        ST_WR_ISSUE: resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv32_lsu.sv
// Self-checking bench for riscv32_lsu: table of directed requests plus
// hand-written sequences for back-to-back accepts and reset mid-operation.
module tb_riscv32_lsu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ram_clear;

  logic [31:0] ram [0:1023];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  riscv32_lsu #(.MEM_ADDR_BITS(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word-wide RAM, one-cycle read latency, no byte enables.
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_wen) ram[mem_addr[11:2]] <= mem_wdata;
      else         mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          wcyc;
    logic [31:0] wword;
    int          ens;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat, input logic err,
                     input logic [31:0] rdata, input int wcyc, input logic [31:0] wword,
                     input int ens);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat; v.err = err;
    v.rdata = rdata; v.wcyc = wcyc; v.wword = wword; v.ens = ens;
    vecs.push_back(v);
  endtask

  // Called at #1 after an edge with the DUT idle; that next edge is cycle 0.
  task automatic run_vec(input vec_t v, input int idx);
    int          c, lat, wcyc, ens;
    logic        err, rdy;
    logic [31:0] rdata, wword, waddr;
    c = 0; lat = 0; wcyc = 0; ens = 0; err = 1'b0; rdy = 1'b0;
    rdata = 32'd0; wword = 32'd0; waddr = 32'd0;
    chk($sformatf("v%0d_ready_at_accept", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    while (c < 10 && lat == 0) begin
      @(posedge clock); #1;
      c++;
      if (c == 1) req_valid = 1'b0;
      if (mem_en) ens++;
      if (mem_wen && wcyc == 0) begin
        wcyc = c; wword = mem_wdata; waddr = mem_addr;
      end
      if (resp_valid) begin
        lat = c; err = resp_err; rdata = resp_rdata; rdy = req_ready;
      end
    end
    chk($sformatf("v%0d_resp_cycle", idx), lat, v.lat);
    chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.err});
    chk($sformatf("v%0d_rdata", idx), rdata, v.rdata);
    chk($sformatf("v%0d_write_cycle", idx), wcyc, v.wcyc);
    chk($sformatf("v%0d_write_word", idx), wword, v.wword);
    chk($sformatf("v%0d_write_addr", idx), waddr, (v.wcyc != 0) ? (v.addr & 32'hFFFF_FFFC) : 32'd0);
    chk($sformatf("v%0d_en_cycles", idx), ens, v.ens);
    chk($sformatf("v%0d_ready_at_resp", idx), {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    int          c, n_acc, n_resp;
    int          acc_cyc [2];
    int          resp_cyc [2];
    logic [31:0] rd [2];
    int          wen_seen, resp_seen;

    reset_n = 1'b0; ram_clear = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1; ram_clear = 1'b0;

    //  wr    f3      addr           wdata          lat err rdata          wcyc wword          ens
    add(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1'b0, 32'h0,          1, 32'hDEAD_BEEF, 1);
    add(1'b0, 3'b010, 32'h0000_0100, 32'h0,          3, 1'b0, 32'hDEAD_BEEF, 0, 32'h0,          1);
    add(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AA, 4, 1'b0, 32'h0,          3, 32'hDEAD_AAEF, 2);
    add(1'b0, 3'b000, 32'h0000_0101, 32'h0,          3, 1'b0, 32'hFFFF_FFAA, 0, 32'h0,          1);
    add(1'b0, 3'b100, 32'h0000_0101, 32'h0,          3, 1'b0, 32'h0000_00AA, 0, 32'h0,          1);
    add(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 4, 1'b0, 32'h0,          3, 32'h1234_AAEF, 2);
    add(1'b0, 3'b001, 32'h0000_0102, 32'h0,          3, 1'b0, 32'h0000_1234, 0, 32'h0,          1);
    add(1'b0, 3'b001, 32'h0000_0100, 32'h0,          3, 1'b0, 32'hFFFF_AAEF, 0, 32'h0,          1);
    add(1'b0, 3'b101, 32'h0000_0100, 32'h0,          3, 1'b0, 32'h0000_AAEF, 0, 32'h0,          1);
    add(1'b0, 3'b010, 32'h0000_0102, 32'h0,          1, 1'b1, 32'h0,          0, 32'h0,          0);
    add(1'b1, 3'b001, 32'h0000_0101, 32'h0000_5555, 1, 1'b1, 32'h0,          0, 32'h0,          0);
    add(1'b0, 3'b011, 32'h0000_0100, 32'h0,          1, 1'b1, 32'h0,          0, 32'h0,          0);
    add(1'b0, 3'b010, 32'h0001_0000, 32'h0,          1, 1'b1, 32'h0,          0, 32'h0,          0);
    add(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0011, 1, 1'b1, 32'h0,          0, 32'h0,          0);
    add(1'b1, 3'b000, 32'h0000_0103, 32'hFFFF_FF55, 4, 1'b0, 32'h0,          3, 32'h5534_AAEF, 2);
    add(1'b0, 3'b000, 32'h0000_0103, 32'h0,          3, 1'b0, 32'h0000_0055, 0, 32'h0,          1);
    add(1'b0, 3'b001, 32'h0000_0102, 32'h0,          3, 1'b0, 32'h0000_5534, 0, 32'h0,          1);
    add(1'b0, 3'b010, 32'h0000_0100, 32'h0,          3, 1'b0, 32'h5534_AAEF, 0, 32'h0,          1);
    add(1'b0, 3'b010, 32'h0000_FFFC, 32'h0,          3, 1'b0, 32'h0,          0, 32'h0,          1);

    @(posedge clock); #1;
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back loads with req_valid held high.
    c = 0; n_acc = 0; n_resp = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; resp_cyc[0] = -1; resp_cyc[1] = -1;
    rd[0] = 32'hX; rd[1] = 32'hX;
    req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
    while (c < 12 && n_resp < 2) begin
      if (req_valid && req_ready && n_acc < 2) begin
        acc_cyc[n_acc] = c; n_acc++;
      end
      @(posedge clock); #1;
      c++;
      if (n_acc == 1) req_addr = 32'h0000_0104;
      if (n_acc == 2) req_valid = 1'b0;
      if (resp_valid) begin
        resp_cyc[n_resp] = c; rd[n_resp] = resp_rdata; n_resp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accept0", acc_cyc[0], 0);
    chk("b2b_accept1", acc_cyc[1], 3);
    chk("b2b_resp0", resp_cyc[0], 3);
    chk("b2b_resp1", resp_cyc[1], 6);
    chk("b2b_rdata0", rd[0], 32'h5534_AAEF);
    chk("b2b_rdata1", rd[1], 32'h0000_0000);

    // SB abandoned by reset during RD_DATA.
    @(posedge clock); #1;
    wen_seen = 0; resp_seen = 0;
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0000_0100;
    req_wdata = 32'h0000_0077;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      if (k == 1) req_valid = 1'b0;
      if (mem_wen) wen_seen++;
      if (resp_valid) resp_seen++;
      if (k == 2) reset_n = 1'b0;
      if (k == 3) begin
        #1;
        chk("rst_mid_ready_low", {31'd0, req_ready}, 32'd0);
        chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
      end
      if (k == 4) chk("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    end
    chk("rst_mid_no_write", wen_seen, 0);
    chk("rst_mid_no_resp", resp_seen, 0);
    begin
      vec_t v;
      v.wr = 1'b0; v.f3 = 3'b010; v.addr = 32'h0000_0100; v.wdata = 32'h0; v.lat = 3;
      v.err = 1'b0; v.rdata = 32'h5534_AAEF; v.wcyc = 0; v.wword = 32'h0; v.ens = 1;
      run_vec(v, 99);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv32_lsu.md
Name: riscv32_lsu

Overview:
Load/store unit on the CPU side of the data-memory port. It drives the word-wide, single-port synchronous data RAM, which has one-cycle read latency and no byte enables. It turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests from the MEM stage into RAM accesses: aligned word access directly, sub-word stores by read-modify-write. Loads get sign or zero extension, and misaligned, illegal or out-of-range requests are flagged.

Parameters:
MEM_ADDR_BITS, 16, byte-address width backed by the data RAM; any request address >= 2**MEM_ADDR_BITS is an error.

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; high only in IDLE and while reset_n=1
req_wr  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits significant for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned, illegal funct3 or out of range
mem_en  out  1  RAM enable
mem_wen  out  1  RAM write enable
mem_addr  out  32  word-aligned RAM byte address ({addr[31:2],2'b00})
mem_wdata  out  32  RAM write word
mem_rdata  in  32  RAM read word, valid the cycle after the read-enable cycle

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; resp_valid=0; resp_err=0; resp_rdata=0; latched addr/data=0. Outputs mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0; req_ready=0 while reset_n=0.
- Accept: req_valid&req_ready at a rising edge (cycle 0 = accept cycle). The request is latched.
- States:
  - IDLE
  - RD_ISSUE: mem_en=1, wen=0
  - RD_DATA: mem_rdata valid
  - WR_ISSUE: mem_en=1, wen=1
- mem_en and mem_wen are decoded from state only; 0 in IDLE and RD_DATA.
- Error check at accept: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 in {011,110,111}; store funct3[2]=1; addr out of range. Result: stay IDLE, no RAM access. Cycle 1: resp_valid=1, resp_err=1, resp_rdata=0, req_ready=1.
- LW/LB/LH/LBU/LHU: IDLE→RD_ISSUE (cycle 1)→RD_DATA (cycle 2)→IDLE. resp_rdata is registered from mem_rdata; resp_valid=1 in cycle 3; req_ready low in cycles 1-2.
- SW: IDLE→WR_ISSUE (cycle 1, mem_wdata=req_wdata)→IDLE. resp_valid in cycle 2, resp_rdata=0.
- SB/SH: IDLE→RD_ISSUE→RD_DATA (merged word registered)→WR_ISSUE (cycle 3, mem_wdata=merged)→IDLE. resp_valid in cycle 4.
- Byte lanes are little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k]
  - halfword occupies bits [16*addr[1]+15 : 16*addr[1]]
  - LB/LH sign-extend; LBU/LHU zero-extend
- resp_valid is exactly one cycle; no backpressure on the response.
- A new request may be accepted in the same cycle resp_valid is high.
- Reset mid-operation abandons the request: no resp_valid, and no write unless WR_ISSUE's edge already occurred.
- mem_addr and mem_wdata hold their last values in IDLE.

Decomposition:
- riscv32_Consts.v gains funct3 macros `LSU_B/H/W/BU/HU and LSU state encodings (2-bit).
- One combinational sub-module, riscv32_lsu_align: extract+extend (load) and merge (store) from word, addr[1:0], funct3.

Test Plan:
1. Reset, then SW addr 0x100 data 0xDEADBEEF → cycle 1 mem_en=1 wen=1 mem_addr=0x100 mem_wdata=0xDEADBEEF; cycle 2 resp_valid=1, err=0. Then LW 0x100 → resp_rdata=0xDEADBEEF in cycle 3.
2. Word=0xDEADBEEF, SB 0x101 data 0x000000AA → read in cycle 1, write 0xDEADAAEF in cycle 3, resp in cycle 4. Then LB 0x101 → 0xFFFFFFAA; LBU 0x101 → 0x000000AA.
3. SH 0x102 data 0x1234 → word 0x1234AAEF. Then LH 0x102 → 0x00001234; LH 0x100 → 0xFFFFAAEF; LHU 0x100 → 0x0000AAEF.
4. LW 0x102, SH 0x101, funct3=011 at 0x100, and LW 0x00010000 (MEM_ADDR_BITS=16) → each gives resp_valid=1, err=1, rdata=0 in cycle 1; mem_en never asserted; req_ready stays 1.
5. req_valid held high with LW 0x100 then LW 0x104 → accepts in cycles 0 and 3, resp_valid in cycles 3 and 6.
6. SB 0x100 accepted, reset_n=0 during the RD_DATA cycle → mem_wen never 1, no resp_valid, word unchanged. req_ready=1 the cycle after reset_n returns high.
